// File: rtl/aes_pkg.sv
// Shared types for the AES decryption controller: opcodes, FSM states, output bundle.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a. Optional AESDECFULL support is selected by the AES_DEC_FULL_EN macro.
package aes_pkg;

    // AES-128 round count
    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [2:0] {
        NOOP            = 3'd0,
        AESENC          = 3'd1,
        AESENCLAST      = 3'd2,
        AESKEYGENASSIST = 3'd3,
        AESDEC          = 3'd4,
        AESDECLAST      = 3'd5,
        AESIMC          = 3'd6,
        AESDECFULL      = 3'd7
    } opcode;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        INV_SBOX = 2'd1,
        ROUND    = 2'd2,
        FINISH   = 2'd3
    } dec_state_t;

    // Moore-decoded control outputs (everything except rnd_cnt and illegal_op)
    typedef struct packed {
        logic inv_sub;
        logic full_dec;
        logic final_rnd;
        logic zero_rnd;
        logic key_sel;
        logic imc_only;
        logic prev_key;
        logic busy;
        logic cipher_ready;
        logic imc_ready;
    } dec_out_t;

    // Opcodes this controller will latch; everything else except NOOP is illegal
    function automatic logic op_supported(opcode op);
        case (op)
            AESDEC, AESDECLAST, AESIMC: return 1'b1;
`ifdef AES_DEC_FULL_EN
            AESDECFULL:                 return 1'b1;
`endif
            default:                    return 1'b0;
        endcase
    endfunction

    // Output decode for a given state / latched opcode / round index
    function automatic dec_out_t dec_decode(dec_state_t st, opcode op, logic [3:0] cnt);
        dec_out_t o;
        o      = '0;
        o.busy = (st != IDLE);
        case (st)
            INV_SBOX: begin
                if (op == AESDECFULL) begin
                    // round 0 of the full inverse cipher is AddRoundKey only
                    o.zero_rnd = 1'b1;
                    o.key_sel  = 1'b1;
                    o.prev_key = 1'b1;
                end else begin
                    o.inv_sub = 1'b1;
                end
            end
            ROUND: begin
                case (op)
                    AESDEC: begin
                        o.full_dec = 1'b1;
                        o.key_sel  = 1'b1;
                    end
                    AESDECLAST: o.final_rnd = 1'b1;
                    AESIMC:     o.imc_only  = 1'b1;
                    AESDECFULL: begin
                        o.key_sel  = 1'b1;
                        o.prev_key = 1'b1;
                        if (cnt == NR) o.final_rnd = 1'b1;
                        else           o.full_dec  = 1'b1;
                    end
                    default: ;
                endcase
            end
            FINISH: begin
                if (op == AESIMC) o.imc_ready    = 1'b1;
                else              o.cipher_ready = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/aes_dec_ctrl_if.sv
// Front-end <-> decryption controller bundle: request strobe/opcode in, datapath controls out.
// Latency: n/a (wiring only).
// Backpressure: requests are dropped while busy_o=1; the front end must hold off itself.
interface aes_dec_ctrl_if;
    logic           start_i;
    aes_pkg::opcode opcode_i;
    logic           inv_sub_o;
    logic           full_dec_o;
    logic           final_rnd_o;
    logic           zero_rnd_o;
    logic           key_sel_o;
    logic           imc_only_o;
    logic           prev_key_o;
    logic [3:0]     rnd_cnt_o;
    logic           busy_o;
    logic           cipher_ready_o;
    logic           imc_ready_o;
    logic           illegal_op_o;

    modport master (
        output start_i, opcode_i,
        input  inv_sub_o, full_dec_o, final_rnd_o, zero_rnd_o, key_sel_o, imc_only_o,
               prev_key_o, rnd_cnt_o, busy_o, cipher_ready_o, imc_ready_o, illegal_op_o
    );

    modport slave (
        input  start_i, opcode_i,
        output inv_sub_o, full_dec_o, final_rnd_o, zero_rnd_o, key_sel_o, imc_only_o,
               prev_key_o, rnd_cnt_o, busy_o, cipher_ready_o, imc_ready_o, illegal_op_o
    );
endinterface

// File: rtl/aes_rnd_cnt.sv
// Round counter for the full inverse cipher: synchronous clear, increment, terminal flag at NR.
// Latency: count updates one cycle after clr_i/inc_i; cnt_nxt_o shows the pending value.
// Backpressure: none; saturates at NR so it never exceeds the round count.
module aes_rnd_cnt
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       nrst,
    input  logic       clr_i,
    input  logic       inc_i,
    output logic [3:0] cnt_o,
    output logic [3:0] cnt_nxt_o,
    output logic       tc_o
);
    logic [3:0] cnt_q, cnt_d;

    // next count: clear wins, increment stops at NR
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                    cnt_d = 4'd0;
        else if (inc_i && cnt_q != NR) cnt_d = cnt_q + 4'd1;
    end

    // count register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) cnt_q <= 4'd0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o     = cnt_q;
    assign cnt_nxt_o = cnt_d;
    assign tc_o      = (cnt_q == NR);
endmodule

// File: rtl/aes_dec_ctrl.sv
// AES inverse-cipher control FSM (AESDEC/AESDECLAST/AESIMC, AESDECFULL under AES_DEC_FULL_EN).
// Latency: cipher_ready 3 cycles after accept (12 for AESDECFULL), imc_ready 2, illegal_op 1.
// Backpressure: start_i only sampled in IDLE; requests while busy are silently dropped.
module aes_dec_ctrl
    import aes_pkg::*;
(
    input  logic          clk,
    input  logic          nrst,
    aes_dec_ctrl_if.slave bus
);
    dec_state_t state_q, state_d;
    opcode      opc_q,   opc_d;
    dec_out_t   out_q,   out_d;
    logic       illegal_q, illegal_d;

    logic       cnt_clr, cnt_inc, cnt_tc;
    logic [3:0] cnt_cur, cnt_nxt;

`ifdef AES_DEC_FULL_EN
    aes_rnd_cnt u_rnd_cnt (
        .clk       (clk),
        .nrst      (nrst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .cnt_o     (cnt_cur),
        .cnt_nxt_o (cnt_nxt),
        .tc_o      (cnt_tc)
    );
`else
    // no multi-round op exists, so there is no counter
    logic cnt_unused;
    assign cnt_unused = cnt_clr | cnt_inc;
    assign cnt_cur    = 4'd0;
    assign cnt_nxt    = 4'd0;
    assign cnt_tc     = 1'b1;
`endif

    // next-state, opcode latch, counter control and registered-output decode
    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        illegal_d = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start_i && bus.opcode_i != NOOP) begin
                    if (op_supported(bus.opcode_i)) begin
                        opc_d   = bus.opcode_i;
                        state_d = (bus.opcode_i == AESIMC) ? ROUND : INV_SBOX;
                        cnt_clr = 1'b1;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            INV_SBOX: begin
                state_d = ROUND;
                cnt_inc = (opc_q == AESDECFULL);
            end
            ROUND: begin
                if (opc_q == AESDECFULL && !cnt_tc) begin
                    cnt_inc = 1'b1;
                end else begin
                    state_d = FINISH;
                    cnt_clr = 1'b1;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // decode from the next state so outputs are flops aligned with state_q
        out_d = dec_decode(state_d, opc_d, cnt_nxt);
    end

    // state, opcode and output registers
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            opc_q     <= NOOP;
            out_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opc_q     <= opc_d;
            out_q     <= out_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.inv_sub_o      = out_q.inv_sub;
    assign bus.full_dec_o     = out_q.full_dec;
    assign bus.final_rnd_o    = out_q.final_rnd;
    assign bus.zero_rnd_o     = out_q.zero_rnd;
    assign bus.key_sel_o      = out_q.key_sel;
    assign bus.imc_only_o     = out_q.imc_only;
    assign bus.prev_key_o     = out_q.prev_key;
    assign bus.busy_o         = out_q.busy;
    assign bus.cipher_ready_o = out_q.cipher_ready;
    assign bus.imc_ready_o    = out_q.imc_ready;
    assign bus.illegal_op_o   = illegal_q;
    assign bus.rnd_cnt_o      = cnt_cur;
endmodule

// File: tb/tb_aes_dec_ctrl.sv
// Self-checking bench for aes_dec_ctrl: timeline reference model feeding a scoreboard queue.
// Latency: expected vector for each clock edge is queued before that edge.
// Backpressure: model drops requests while the previous expected cycle was busy.
module tb_aes_dec_ctrl;
    import aes_pkg::*;

    logic clk  = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    aes_dec_ctrl_if bus ();

    aes_dec_ctrl dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    // output vector layout: one bit per flag, rnd_cnt in [14:11]
    typedef logic [14:0] vec_t;
    localparam vec_t V_INV  = 15'h0001;
    localparam vec_t V_FD   = 15'h0002;
    localparam vec_t V_FR   = 15'h0004;
    localparam vec_t V_ZR   = 15'h0008;
    localparam vec_t V_KS   = 15'h0010;
    localparam vec_t V_IMC  = 15'h0020;
    localparam vec_t V_PK   = 15'h0040;
    localparam vec_t V_BUSY = 15'h0080;
    localparam vec_t V_CR   = 15'h0100;
    localparam vec_t V_IR   = 15'h0200;
    localparam vec_t V_ILL  = 15'h0400;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t timeline[$];   // future per-cycle outputs of the op in flight
    vec_t exp_q[$];      // scoreboard: one expected vector per clock edge
    vec_t last_exp = '0;

    function automatic vec_t cnt_v(int c);
        vec_t v;
        v = vec_t'(c) << 11;
        return v;
    endfunction

    function automatic vec_t dut_vec();
        vec_t v;
        v = '0;
        v[0]     = bus.inv_sub_o;
        v[1]     = bus.full_dec_o;
        v[2]     = bus.final_rnd_o;
        v[3]     = bus.zero_rnd_o;
        v[4]     = bus.key_sel_o;
        v[5]     = bus.imc_only_o;
        v[6]     = bus.prev_key_o;
        v[7]     = bus.busy_o;
        v[8]     = bus.cipher_ready_o;
        v[9]     = bus.imc_ready_o;
        v[10]    = bus.illegal_op_o;
        v[14:11] = bus.rnd_cnt_o;
        return v;
    endfunction

    function automatic void check(string name, vec_t got, vec_t want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endfunction

    // drive one request cycle and queue the expected outputs after the next edge
    task automatic step(input logic s, input opcode op);
        @(negedge clk);
        bus.start_i  = s;
        bus.opcode_i = op;
        if (s && !last_exp[7]) begin
            case (op)
                AESDEC: begin
                    timeline.push_back(V_BUSY | V_INV);
                    timeline.push_back(V_BUSY | V_FD | V_KS);
                    timeline.push_back(V_BUSY | V_CR);
                end
                AESDECLAST: begin
                    timeline.push_back(V_BUSY | V_INV);
                    timeline.push_back(V_BUSY | V_FR);
                    timeline.push_back(V_BUSY | V_CR);
                end
                AESIMC: begin
                    timeline.push_back(V_BUSY | V_IMC);
                    timeline.push_back(V_BUSY | V_IR);
                end
                AESDECFULL: begin
`ifdef AES_DEC_FULL_EN
                    timeline.push_back(V_BUSY | V_ZR | V_KS | V_PK);
                    for (int r = 1; r <= 10; r++)
                        timeline.push_back(V_BUSY | V_KS | V_PK | ((r == 10) ? V_FR : V_FD) | cnt_v(r));
                    timeline.push_back(V_BUSY | V_CR);
`else
                    timeline.push_back(V_ILL);
`endif
                end
                NOOP:    ;
                default: timeline.push_back(V_ILL);
            endcase
        end
        last_exp = (timeline.size() != 0) ? timeline.pop_front() : '0;
        exp_q.push_back(last_exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, NOOP);
    endtask

    // monitor: compare every edge's outputs with the scoreboard head
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) check("cycle", dut_vec(), exp_q.pop_front());
        end
    end

    initial begin
        bus.start_i  = 1'b0;
        bus.opcode_i = NOOP;
        #12;
        check("reset_state", dut_vec(), '0);
        @(negedge clk);
        nrst = 1'b1;
        exp_q.push_back('0);

        // directed: each op type, busy drop, illegal opcodes
        step(1'b1, AESDEC);      idle(4);
        step(1'b1, AESDECLAST);  step(1'b1, AESDEC); idle(4);
        step(1'b1, AESIMC);      idle(3);
        step(1'b1, AESKEYGENASSIST); idle(2);
        step(1'b1, AESENC);      idle(2);
        step(1'b1, AESDECFULL);  idle(14);
        // back-to-back: second request right after FINISH
        step(1'b1, AESIMC); idle(2); step(1'b1, AESDEC); idle(4);

        // async reset while AESDEC is in ROUND
        step(1'b1, AESDEC); idle(1);
        @(negedge clk);
        nrst = 1'b0;
        timeline.delete();
        last_exp = '0;
        #1;
        check("async_rst", dut_vec(), '0);
        exp_q.push_back('0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            exp_q.push_back('0);
        end
        nrst = 1'b1;
        idle(5);

        // random traffic
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 2) == 0), opcode'($urandom_range(0, 7)));
        idle(16);

        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_dec_ctrl.md
# aes_dec_ctrl

Control FSM for the AES decryption datapath, the inverse-cipher counterpart of the encryption controller. It accepts AESDEC, AESDECLAST and AESIMC opcodes, plus AESDECFULL when compiled in. It sequences inverse S-box substitution, the inverse round and key selection, then pulses a completion flag. It sits between the instruction front end and the inverse-cipher datapath, inverse S-box and round-key store.

## Interface
- No parameters; round count fixed at 10 (AES-128), held as `aes_pkg::NR`.
- clk  in  1  clock
- nrst  in  1  reset, asynchronous, active-low
- start_i  in  1  request strobe; sampled only when busy_o=0
- opcode_i  in  aes_pkg::opcode  operation, valid with start_i
- inv_sub_o  out  1  select inverse S-box / InvSubBytes stage
- full_dec_o  out  1  round includes InvMixColumns
- final_rnd_o  out  1  last round (no InvMixColumns)
- zero_rnd_o  out  1  initial AddRoundKey only
- key_sel_o  out  1  0 = external key operand, 1 = key store
- imc_only_o  out  1  InvMixColumns-only path (AESIMC)
- prev_key_o  out  1  request key store to step to previous round key
- rnd_cnt_o  out  4  current round index
- busy_o  out  1  operation in progress
- cipher_ready_o  out  1  one-cycle pulse: state result valid
- imc_ready_o  out  1  one-cycle pulse: AESIMC result valid
- illegal_op_o  out  1  one-cycle pulse: rejected opcode

## Operation
- States: IDLE, INV_SBOX, ROUND, FINISH.
- All outputs are Moore-decoded from the state, the latched opcode and rnd_cnt. There is no combinational path from start_i or opcode_i to any output.
- IDLE: all outputs 0, rnd_cnt=0.
  - start_i=1 with a supported opcode latches the opcode.
  - NOOP is ignored silently.
  - An unsupported opcode stays in IDLE, latches nothing, and pulses illegal_op_o next cycle.
- AESDEC: IDLE→INV_SBOX (inv_sub_o=1)→ROUND (full_dec_o=1, key_sel_o=1)→FINISH (cipher_ready_o=1)→IDLE.
- AESDECLAST: same path; ROUND drives final_rnd_o=1, full_dec_o=0, key_sel_o=0.
- AESIMC: IDLE→ROUND (imc_only_o=1, all else 0)→FINISH (imc_ready_o=1)→IDLE.
- busy_o=1 in every non-IDLE state.
- start_i while busy is ignored: no latch, no illegal_op_o.
- FINISH always returns to IDLE. Back-to-back requests are accepted in IDLE only, one cycle after FINISH.
- Async reset at any point forces IDLE, clears the opcode register to NOOP, clears rnd_cnt, and drives all outputs 0. No ready pulse is emitted for an aborted operation.

## Timing
- Accept edge = rising edge where IDLE && start_i && supported opcode.
- cipher_ready_o asserts 3 cycles after the accept edge for AESDEC/AESDECLAST.
- imc_ready_o asserts 2 cycles after the accept edge for AESIMC.
- Ready pulses are exactly 1 cycle wide.
- illegal_op_o asserts 1 cycle after the offending edge and lasts 1 cycle.
- AESDECFULL: cipher_ready_o asserts 12 cycles after the accept edge.

## Configuration
- `AES_DEC_FULL_EN` defined: AESDECFULL is supported.
  - INV_SBOX holds rnd_cnt=0 with zero_rnd_o=1, key_sel_o=1, prev_key_o=1.
  - ROUND then loops with rnd_cnt 1..10 and prev_key_o=1 each cycle. Rounds 1–9 drive full_dec_o=1; round 10 drives final_rnd_o=1.
  - After round 10 the FSM goes to FINISH.
  - rnd_cnt wraps to 0 on FINISH and never exceeds NR.
- Macro undefined: AESDECFULL is an unsupported opcode (illegal_op_o). The round counter is removed, and rnd_cnt_o is tied to 0 for non-full ops as well.

## Structure
- `aes_pkg` holds the opcode enum (extended with AESDEC, AESDECLAST, AESIMC, AESDECFULL), the NR constant, and the state enum type `dec_state_t`.
- A single sub-module `aes_rnd_cnt` (load/increment/terminal-count flag at NR) is instantiated only under `AES_DEC_FULL_EN`.

## Test plan
- Reset: nrst low mid-AESDEC in ROUND → all outputs 0 immediately; after release, busy_o=0 and no cipher_ready_o pulse.
- AESDEC at cycle 0 → inv_sub_o=1 @1, full_dec_o=key_sel_o=1 @2, cipher_ready_o=1 @3 only, busy_o=0 @4.
- AESDECLAST → final_rnd_o=1, full_dec_o=0 @2; cipher_ready_o @3. A second start_i @1 with AESDEC is ignored.
- AESIMC → imc_only_o=1 @1, imc_ready_o=1 @2; inv_sub_o never asserted.
- AESKEYGENASSIST and AESENC opcodes → illegal_op_o pulse @1, busy_o stays 0.
- With `AES_DEC_FULL_EN`: AESDECFULL → rnd_cnt 0..10 over cycles 1..11, final_rnd_o only @11, prev_key_o high cycles 1–11, cipher_ready_o @12. Without the macro → illegal_op_o @1.
